// File: rtl/mbinit_sb_pkg.sv
// mbinit_sb_pkg: shared MBINIT sideband message codes, arbiter states and defaults
package mbinit_sb_pkg;
  typedef logic [3:0] sb_msg_t;
  localparam sb_msg_t MSG_CAL_DONE_REQ = 4'b0001;
  localparam sb_msg_t MSG_CAL_DONE_RESP = 4'b0010;
  localparam int DEF_TIMEOUT = 1023;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_FALL,
    ST_HOLDOFF
  } sb_state_e;
endpackage

// File: rtl/mbinit_sb_tx_arbiter_if.sv
// mbinit_sb_tx_arbiter_if: requester, serializer and status signals of the sideband TX arbiter
interface mbinit_sb_tx_arbiter_if;
  import mbinit_sb_pkg::*;
  logic i_enable;
  logic i_req_valid_0;
  logic i_req_valid_1;
  sb_msg_t i_req_msg_0;
  sb_msg_t i_req_msg_1;
  logic i_sb_busy;
  logic o_sb_valid;
  sb_msg_t o_sb_msg;
  logic [1:0] o_grant;
  logic o_busy_0;
  logic o_busy_1;
  logic o_fall_0;
  logic o_fall_1;
  logic o_timeout;
  modport slave (
    input i_enable, i_req_valid_0, i_req_valid_1, i_req_msg_0, i_req_msg_1, i_sb_busy,
    output o_sb_valid, o_sb_msg, o_grant, o_busy_0, o_busy_1, o_fall_0, o_fall_1, o_timeout
  );
  modport master (
    output i_enable, i_req_valid_0, i_req_valid_1, i_req_msg_0, i_req_msg_1, i_sb_busy,
    input o_sb_valid, o_sb_msg, o_grant, o_busy_0, o_busy_1, o_fall_0, o_fall_1, o_timeout
  );
endinterface

// File: rtl/mbinit_sb_wdog.sv
// mbinit_sb_wdog: saturating cycle counter that expires on the LIMIT-th cycle after a clear
module mbinit_sb_wdog #(
  parameter int LIMIT = 1
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic clr,
  output logic expire
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  // count cycles since the last clear, holding at LIMIT
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (cnt != W'(LIMIT)) cnt <= cnt + 1'b1;
  assign expire = cnt >= W'(LIMIT - 1);
endmodule

// File: rtl/mbinit_sb_tx_arbiter.sv
// mbinit_sb_tx_arbiter: round-robin share of the MBINIT sideband TX path between two requesters
module mbinit_sb_tx_arbiter
  import mbinit_sb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int HOLDOFF_CYC = 2
) (
  input logic CLK,
  input logic rst_n,
  mbinit_sb_tx_arbiter_if.slave bus
);
  sb_state_e state, state_n;
  logic ptr, ptr_n, own, own_n, pick, any_req, clr, to_exp, ho_exp, tout_n, fall_n;
  sb_msg_t msg_n;
  assign any_req = bus.i_req_valid_0 | bus.i_req_valid_1;
  assign pick = (bus.i_req_valid_0 & bus.i_req_valid_1) ? ptr : bus.i_req_valid_1;
  assign clr = !bus.i_enable || (state_n != state);
  assign bus.o_busy_0 = bus.i_sb_busy | (state != ST_IDLE);
  assign bus.o_busy_1 = bus.i_sb_busy | (state != ST_IDLE);
  mbinit_sb_wdog #(.LIMIT(TIMEOUT)) u_wdog (.CLK(CLK), .rst_n(rst_n), .clr(clr), .expire(to_exp));
  mbinit_sb_wdog #(.LIMIT(HOLDOFF_CYC)) u_hold (.CLK(CLK), .rst_n(rst_n), .clr(clr), .expire(ho_exp));
  // next state, round-robin pick, message latch and watchdog abort
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    own_n = own;
    msg_n = bus.o_sb_msg;
    fall_n = 1'b0;
    tout_n = bus.o_timeout;
    if (!bus.i_enable) begin
      state_n = ST_IDLE;
      ptr_n = 1'b0;
      tout_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (!bus.i_sb_busy && any_req) begin
          state_n = ST_ISSUE;
          own_n = pick;
          ptr_n = ~pick;
          msg_n = pick ? bus.i_req_msg_1 : bus.i_req_msg_0;
        end
        ST_ISSUE: if (bus.i_sb_busy) state_n = ST_WAIT_FALL;
        else if (to_exp) begin
          state_n = ST_HOLDOFF;
          tout_n = 1'b1;
        end
        ST_WAIT_FALL: if (!bus.i_sb_busy) begin
          state_n = ST_HOLDOFF;
          fall_n = 1'b1;
        end else if (to_exp) begin
          state_n = ST_HOLDOFF;
          tout_n = 1'b1;
        end
        default: if (ho_exp) state_n = ST_IDLE;
      endcase
    end
  end
  // state register and outputs registered from the next state
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr <= 1'b0;
      own <= 1'b0;
      bus.o_sb_msg <= '0;
      bus.o_sb_valid <= 1'b0;
      bus.o_grant <= 2'b00;
      bus.o_fall_0 <= 1'b0;
      bus.o_fall_1 <= 1'b0;
      bus.o_timeout <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      own <= own_n;
      bus.o_sb_msg <= msg_n;
      bus.o_sb_valid <= state_n == ST_ISSUE;
      bus.o_grant <= (state_n == ST_ISSUE || state_n == ST_WAIT_FALL) ? (own_n ? 2'b10 : 2'b01) : 2'b00;
      bus.o_fall_0 <= fall_n & !own;
      bus.o_fall_1 <= fall_n & own;
      bus.o_timeout <= tout_n;
    end
endmodule

// File: tb/tb_mbinit_sb_tx_arbiter.sv
// tb_mbinit_sb_tx_arbiter: scoreboard bench for the sideband TX arbiter
module tb_mbinit_sb_tx_arbiter;
  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [5:0] exp_q[$];
  logic [5:0] e;
  int f0, f1, fidx, wc, bad;
  logic [1:0] gwf, gaft, og;
  logic [3:0] om, mwf;
  logic sv1;
  mbinit_sb_tx_arbiter_if bus();
  mbinit_sb_tx_arbiter #(.TIMEOUT(8), .HOLDOFF_CYC(2)) dut (.CLK(CLK), .rst_n(rst_n), .bus(bus));
  always #5 CLK = ~CLK;
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal;
  end
  function automatic logic [5:0] pop_exp();
    return exp_q.size() != 0 ? exp_q.pop_front() : 6'h3f;
  endfunction
  task automatic wait_grant();
    wc = 0;
    while (!bus.o_sb_valid && wc < 40) begin
      @(negedge CLK);
      wc++;
    end
    og = bus.o_grant;
    om = bus.o_sb_msg;
  endtask
  task automatic complete(input int bc);
    bus.i_sb_busy = 1'b1;
    @(negedge CLK);
    sv1 = bus.o_sb_valid;
    repeat (bc - 1) @(negedge CLK);
    gwf = bus.o_grant;
    mwf = bus.o_sb_msg;
    bus.i_sb_busy = 1'b0;
    f0 = 0;
    f1 = 0;
    fidx = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      if (i == 1) gaft = bus.o_grant;
      if ((bus.o_fall_0 || bus.o_fall_1) && fidx == 0) fidx = i;
      f0 += int'(bus.o_fall_0);
      f1 += int'(bus.o_fall_1);
    end
  endtask
  task automatic test_reset();
    bus.i_enable = 1'b1;
    bus.i_req_valid_0 = 1'b0;
    bus.i_req_valid_1 = 1'b0;
    bus.i_req_msg_0 = 4'b0000;
    bus.i_req_msg_1 = 4'b0000;
    bus.i_sb_busy = 1'b0;
    repeat (2) @(negedge CLK);
    n_tests++; if ({bus.o_sb_valid, bus.o_sb_msg, bus.o_grant, bus.o_fall_0, bus.o_fall_1, bus.o_timeout, bus.o_busy_0, bus.o_busy_1} !== 12'b0) begin n_fail++; $display("FAIL reset_outputs: got %b want all zero", {bus.o_sb_valid, bus.o_sb_msg, bus.o_grant, bus.o_fall_0, bus.o_fall_1, bus.o_timeout, bus.o_busy_0, bus.o_busy_1}); end
    bus.i_sb_busy = 1'b1;
    #1;
    n_tests++; if ({bus.o_busy_0, bus.o_busy_1} !== 2'b11) begin n_fail++; $display("FAIL reset_busy: got %b want 11", {bus.o_busy_0, bus.o_busy_1}); end
    bus.i_sb_busy = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
  endtask
  task automatic test_single();
    bus.i_req_msg_1 = 4'b0010;
    bus.i_req_valid_1 = 1'b1;
    exp_q.push_back({2'b10, 4'b0010});
    wait_grant();
    e = pop_exp();
    n_tests++; if (wc !== 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", wc); end
    n_tests++; if ({og, om} !== e) begin n_fail++; $display("FAIL single_grant: got %b want %b", {og, om}, e); end
    bus.i_req_msg_1 = 4'b1111;
    bus.i_req_valid_1 = 1'b0;
    complete(5);
    n_tests++; if (sv1 !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b want 0", sv1); end
    n_tests++; if ({gwf, mwf} !== {2'b10, 4'b0010}) begin n_fail++; $display("FAIL single_hold: got %b want 100010", {gwf, mwf}); end
    n_tests++; if ({f0, f1, fidx} !== {32'd0, 32'd1, 32'd1}) begin n_fail++; $display("FAIL single_fall: got f0=%0d f1=%0d at %0d want 0 1 1", f0, f1, fidx); end
    n_tests++; if (gaft !== 2'b00) begin n_fail++; $display("FAIL single_grant_drop: got %b want 00", gaft); end
  endtask
  task automatic test_back_to_back();
    bus.i_req_msg_0 = 4'b0001;
    bus.i_req_msg_1 = 4'b0010;
    bus.i_req_valid_0 = 1'b1;
    bus.i_req_valid_1 = 1'b1;
    exp_q.push_back({2'b01, 4'b0001});
    exp_q.push_back({2'b10, 4'b0010});
    wait_grant();
    e = pop_exp();
    n_tests++; if ({og, om} !== e) begin n_fail++; $display("FAIL b2b_first: got %b want %b", {og, om}, e); end
    bus.i_req_valid_0 = 1'b0;
    complete(3);
    n_tests++; if ({f0, f1} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL b2b_fall0: got %0d %0d want 1 0", f0, f1); end
    wait_grant();
    e = pop_exp();
    n_tests++; if (wc !== 1) begin n_fail++; $display("FAIL b2b_holdoff: got %0d want 1", wc); end
    n_tests++; if ({og, om} !== e) begin n_fail++; $display("FAIL b2b_second: got %b want %b", {og, om}, e); end
    bus.i_req_valid_1 = 1'b0;
    complete(2);
    n_tests++; if ({f0, f1} !== {32'd0, 32'd1}) begin n_fail++; $display("FAIL b2b_fall1: got %0d %0d want 0 1", f0, f1); end
    bus.i_req_valid_0 = 1'b1;
    exp_q.push_back({2'b01, 4'b0001});
    wait_grant();
    e = pop_exp();
    n_tests++; if ({og, om} !== e) begin n_fail++; $display("FAIL rr_single0: got %b want %b", {og, om}, e); end
    bus.i_req_valid_0 = 1'b0;
    complete(1);
    bus.i_req_valid_0 = 1'b1;
    bus.i_req_valid_1 = 1'b1;
    exp_q.push_back({2'b10, 4'b0010});
    exp_q.push_back({2'b01, 4'b0001});
    wait_grant();
    e = pop_exp();
    n_tests++; if ({og, om} !== e) begin n_fail++; $display("FAIL rr_first1: got %b want %b", {og, om}, e); end
    bus.i_req_valid_1 = 1'b0;
    complete(2);
    wait_grant();
    e = pop_exp();
    n_tests++; if ({og, om} !== e) begin n_fail++; $display("FAIL rr_then0: got %b want %b", {og, om}, e); end
    bus.i_req_valid_0 = 1'b0;
    complete(2);
  endtask
  task automatic test_busy_high();
    bus.i_sb_busy = 1'b1;
    bus.i_req_msg_0 = 4'b0001;
    bus.i_req_valid_0 = 1'b1;
    exp_q.push_back({2'b01, 4'b0001});
    bad = 0;
    repeat (5) begin
      @(negedge CLK);
      if (bus.o_sb_valid || bus.o_grant != 2'b00 || !bus.o_busy_0) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL busy_block: got %0d bad cycles want 0", bad); end
    bus.i_sb_busy = 1'b0;
    wait_grant();
    e = pop_exp();
    n_tests++; if (wc !== 1 || {og, om} !== e) begin n_fail++; $display("FAIL busy_grant: got %0d %b want 1 %b", wc, {og, om}, e); end
    bus.i_req_valid_0 = 1'b0;
    complete(2);
  endtask
  task automatic test_timeout();
    bus.i_req_msg_1 = 4'b0010;
    bus.i_req_valid_1 = 1'b1;
    exp_q.push_back({2'b10, 4'b0010});
    wait_grant();
    e = pop_exp();
    n_tests++; if ({og, om} !== e) begin n_fail++; $display("FAIL tmo_grant: got %b want %b", {og, om}, e); end
    bus.i_req_valid_1 = 1'b0;
    bad = 0;
    for (int k = 2; k <= 8; k++) begin
      @(negedge CLK);
      if (!bus.o_sb_valid || bus.o_timeout || bus.o_fall_0 || bus.o_fall_1) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL tmo_early: got %0d bad cycles want 0", bad); end
    @(negedge CLK);
    n_tests++; if ({bus.o_timeout, bus.o_sb_valid, bus.o_grant, bus.o_fall_0, bus.o_fall_1, bus.o_busy_0} !== 7'b1000001) begin n_fail++; $display("FAIL tmo_fire: got %b want 1000001", {bus.o_timeout, bus.o_sb_valid, bus.o_grant, bus.o_fall_0, bus.o_fall_1, bus.o_busy_0}); end
    repeat (2) @(negedge CLK);
    n_tests++; if ({bus.o_busy_0, bus.o_fall_1} !== 2'b00) begin n_fail++; $display("FAIL tmo_idle: got %b want 00", {bus.o_busy_0, bus.o_fall_1}); end
    repeat (3) @(negedge CLK);
    n_tests++; if (bus.o_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", bus.o_timeout); end
    bus.i_enable = 1'b0;
    @(negedge CLK);
    n_tests++; if (bus.o_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b want 0", bus.o_timeout); end
    bus.i_enable = 1'b1;
  endtask
  task automatic test_enable_abort();
    bus.i_req_msg_0 = 4'b0001;
    bus.i_req_valid_0 = 1'b1;
    exp_q.push_back({2'b01, 4'b0001});
    wait_grant();
    e = pop_exp();
    n_tests++; if ({og, om} !== e) begin n_fail++; $display("FAIL abort_grant: got %b want %b", {og, om}, e); end
    bus.i_req_valid_0 = 1'b0;
    bus.i_sb_busy = 1'b1;
    @(negedge CLK);
    bus.i_enable = 1'b0;
    bus.i_req_msg_1 = 4'b0010;
    bus.i_req_valid_0 = 1'b1;
    bus.i_req_valid_1 = 1'b1;
    @(negedge CLK);
    n_tests++; if ({bus.o_sb_valid, bus.o_grant, bus.o_fall_0, bus.o_fall_1, bus.o_timeout, bus.o_busy_0} !== 7'b0000001) begin n_fail++; $display("FAIL abort_clear: got %b want 0000001", {bus.o_sb_valid, bus.o_grant, bus.o_fall_0, bus.o_fall_1, bus.o_timeout, bus.o_busy_0}); end
    bus.i_enable = 1'b1;
    @(negedge CLK);
    n_tests++; if (bus.o_sb_valid !== 1'b0) begin n_fail++; $display("FAIL abort_busy_hold: got %b want 0", bus.o_sb_valid); end
    exp_q.push_back({2'b01, 4'b0001});
    exp_q.push_back({2'b10, 4'b0010});
    bus.i_sb_busy = 1'b0;
    wait_grant();
    e = pop_exp();
    n_tests++; if (wc !== 1 || {og, om} !== e) begin n_fail++; $display("FAIL abort_ptr_reset: got %0d %b want 1 %b", wc, {og, om}, e); end
    bus.i_req_valid_0 = 1'b0;
    complete(1);
    wait_grant();
    e = pop_exp();
    n_tests++; if ({og, om} !== e) begin n_fail++; $display("FAIL abort_second: got %b want %b", {og, om}, e); end
    bus.i_req_valid_1 = 1'b0;
    complete(1);
  endtask
  task automatic test_async_reset();
    bus.i_req_msg_1 = 4'b0010;
    bus.i_req_valid_1 = 1'b1;
    exp_q.push_back({2'b10, 4'b0010});
    wait_grant();
    e = pop_exp();
    n_tests++; if ({og, om} !== e) begin n_fail++; $display("FAIL areset_grant: got %b want %b", {og, om}, e); end
    bus.i_req_valid_1 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if ({bus.o_sb_valid, bus.o_sb_msg, bus.o_grant, bus.o_fall_0, bus.o_fall_1, bus.o_timeout, bus.o_busy_0, bus.o_busy_1} !== 12'b0) begin n_fail++; $display("FAIL areset_outputs: got %b want all zero", {bus.o_sb_valid, bus.o_sb_msg, bus.o_grant, bus.o_fall_0, bus.o_fall_1, bus.o_timeout, bus.o_busy_0, bus.o_busy_1}); end
    @(negedge CLK);
    rst_n = 1'b1;
    bus.i_req_valid_1 = 1'b1;
    exp_q.push_back({2'b10, 4'b0010});
    wait_grant();
    e = pop_exp();
    n_tests++; if (wc !== 1 || {og, om} !== e) begin n_fail++; $display("FAIL areset_resume: got %0d %b want 1 %b", wc, {og, om}, e); end
    bus.i_req_valid_1 = 1'b0;
    complete(3);
    n_tests++; if ({f0, f1} !== {32'd0, 32'd1}) begin n_fail++; $display("FAIL areset_fall: got %0d %0d want 0 1", f0, f1); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_high();
    test_timeout();
    test_enable_abort();
    test_async_reset();
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mbinit_sb_tx_arbiter.md
# mbinit_sb_tx_arbiter

Shares the single MBINIT sideband TX message path between two requesters: the initiator-side and partner-side handshake FSMs of each MBINIT sub-phase (CAL, PARAM, …). Grants one requester at a time with round-robin priority and forwards its 4-bit message to the sideband serializer. Each requester gets its own busy/falling-edge view, so the existing FSMs run unchanged. A watchdog flags a serializer that never starts or never finishes.

## Interface
- TIMEOUT, 1023: max cycles in ISSUE or WAIT_FALL before abort (≥1).
- HOLDOFF_CYC, 2: idle cycles after each completion/abort before re-arbitration (≥1).
- CLK  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_enable  in  1  MBINIT sub-phase active; low = synchronous abort/clear.
- i_req_valid_0 / i_req_valid_1  in  1  level request from requester 0 (initiator) / 1 (partner).
- i_req_msg_0 / i_req_msg_1  in  4  message to send; sampled only at grant.
- i_sb_busy  in  1  serializer busy (high while transmitting).
- o_sb_valid  out  1  message valid to serializer.
- o_sb_msg  out  4  granted message.
- o_grant  out  2  one-hot owner, held from grant through WAIT_FALL.
- o_busy_0 / o_busy_1  out  1  per-requester busy = i_sb_busy | (state≠IDLE); combinational from state reg.
- o_fall_0 / o_fall_1  out  1  one-cycle completion pulse to the owning requester.
- o_timeout  out  1  sticky watchdog error.

## Operation
- States: IDLE, ISSUE, WAIT_FALL, HOLDOFF.
- IDLE: if i_enable & !i_sb_busy & any valid → pick requester, latch its msg, set o_grant → ISSUE.
- Pick: if both valid, take ptr; else the one valid. ptr = 0 after reset or i_enable low; after granting k, ptr = ~k.
- ISSUE: o_sb_valid=1, o_sb_msg=latched. i_sb_busy high → WAIT_FALL. TIMEOUT cycles without busy → o_timeout=1 → HOLDOFF.
- WAIT_FALL: busy low (after high) → pulse o_fall_k for owner k → HOLDOFF. TIMEOUT cycles still busy → o_timeout=1 → HOLDOFF, no o_fall.
- HOLDOFF: o_grant=0 for HOLDOFF_CYC cycles → IDLE. Owner must drop valid within HOLDOFF_CYC cycles of its o_fall; a still-asserted valid is a new request.
- Msg changes after grant are ignored.
- i_enable low, any state: next cycle state=IDLE, ptr=0, o_timeout=0, o_sb_valid/o_grant/o_fall=0. No new grant while i_sb_busy is still high.
- Watchdog counter width $clog2(TIMEOUT+1). Cleared on every state entry, saturating.

## Timing
- Reset: state IDLE, ptr 0. o_sb_valid 0, o_sb_msg 4'b0000, o_grant 2'b00, o_fall_* 0, o_timeout 0. o_busy_* = i_sb_busy.
- All outputs except o_busy_* are registered, driven from next_state.
- Grant latency 1: request sampled at edge E0 → o_grant, o_sb_valid, o_sb_msg valid after E0.
- i_sb_busy sampled high at E1 → o_sb_valid low after E1.
- i_sb_busy sampled low at E2 in WAIT_FALL → o_fall_k high for the single cycle after E2. o_grant drops at the same edge.
- HOLDOFF spans HOLDOFF_CYC cycles, so the earliest next grant is at edge E2+HOLDOFF_CYC+1.
- i_enable low at the same edge as a request: abort wins, no grant.

## Structure
- Shared package mbinit_sb_pkg holds:
  - message codes MSG_CAL_DONE_REQ=4'b0001, MSG_CAL_DONE_RESP=4'b0010;
  - state encoding (2-bit);
  - the default TIMEOUT.
- Sub-module mbinit_sb_wdog: parameterized saturating cycle counter with clear and expire outputs. Reused by other MBINIT blocks.

## Test plan
- Single request: valid_1=1, msg_1=4'b0010, busy low → o_sb_msg=4'b0010, o_grant=2'b10 next cycle. Busy high 5 cycles then low → exactly one o_fall_1 pulse, no o_fall_0.
- Simultaneous requests after reset, msg_0=4'b0001, msg_1=4'b0010 → requester 0 served first, then 1 after HOLDOFF_CYC. Repeat both → order alternates 1,0 per ptr.
- Busy already high when valid_0 rises → no grant until busy sampled low. o_busy_0 high throughout.
- TIMEOUT=8, busy never rises → o_timeout=1 after 8 ISSUE cycles, no o_fall, HOLDOFF then IDLE. o_timeout clears only on i_enable low.
- i_enable dropped in WAIT_FALL → next cycle all outputs 0, state IDLE, ptr 0. Re-enable with both valid → requester 0 granted.
- Async reset asserted mid-ISSUE → all outputs return to reset values immediately. Release → normal single-request flow resumes.
